// File: rtl/adc_pkg.sv
// Shared types and default parameters for the dual-slope converter front end.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_INTEG = 3'd2,
    ST_DEINT = 3'd3,
    ST_DONE  = 3'd4
  } trig_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_AUTO_PERIOD     = 4000;
  localparam int DEF_DEINT_TIMEOUT   = 1100;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer and debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce
  import adc_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_s,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   acc_q, acc_d;
  logic                   rise_q, rise_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    rise_d = 1'b0;
    // A level must stay different from the accepted one for the full window.
    if (btn_s == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      acc_d  = btn_s;
      cnt_d  = '0;
      rise_d = btn_s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      sync_q <= '0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      rise_q <= rise_d;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/adc_trigger_sync.sv
// Start/zero-crossing conditioning for the dual-slope conversion controller.
//   state | meaning
//   IDLE  | waiting for a button or auto trigger
//   START | inicio sent, waiting for ch_vm
//   INTEG | integrating, waiting for ch_vr
//   DEINT | deintegrating, comparator edges forwarded, timeout armed
//   DONE  | one-cycle settle before IDLE
module adc_trigger_sync
  import adc_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD,
  parameter int DEINT_TIMEOUT   = DEF_DEINT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_s,
  input  logic start_btn,
  input  logic auto_mode,
  input  logic vint_cmp,
  input  logic ch_vm,
  input  logic ch_vr,
  input  logic ch_zr,
  output logic inicio,
  output logic Vint_z,
  output logic busy,
  output logic overrange
);

  localparam int AW = $clog2(AUTO_PERIOD);
  localparam int DW = $clog2(DEINT_TIMEOUT);
  localparam logic [AW-1:0] AUTO_TC  = AW'(AUTO_PERIOD - 1);
  localparam logic [DW-1:0] DEINT_TC = DW'(DEINT_TIMEOUT - 1);

  trig_state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] cmp_sync_q, cmp_sync_d;
  logic                   cmp_prev_q, cmp_prev_d;
  logic [AW-1:0]          auto_q, auto_d;
  logic [DW-1:0]          deint_q, deint_d;
  logic                   inicio_q, inicio_d;
  logic                   vint_q, vint_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;

  logic btn_rise;
  logic cmp_s;
  logic cmp_edge;
  logic auto_trig;
  logic trig;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_s   (rst_s),
    .btn_raw (start_btn),
    .btn_rise(btn_rise)
  );

  assign cmp_s     = cmp_sync_q[SYNC_STAGES-1];
  assign cmp_edge  = cmp_s & ~cmp_prev_q;
  assign auto_trig = (state_q == ST_IDLE) && auto_mode && (auto_q == AUTO_TC);
  assign trig      = btn_rise | auto_trig;

  always_comb begin
    cmp_sync_d = {cmp_sync_q[SYNC_STAGES-2:0], vint_cmp};
    cmp_prev_d = cmp_s;

    auto_d = '0;
    if ((state_q == ST_IDLE) && auto_mode && (auto_q != AUTO_TC)) begin
      auto_d = auto_q + AW'(1);
    end

    state_d  = state_q;
    deint_d  = deint_q;
    inicio_d = 1'b0;
    vint_d   = 1'b0;
    ovr_d    = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          inicio_d = 1'b1;
          ovr_d    = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (ch_vm) state_d = ST_INTEG;
      end
      ST_INTEG: begin
        if (ch_vr) begin
          deint_d = '0;
          state_d = ST_DEINT;
        end
      end
      ST_DEINT: begin
        // A real edge wins over a simultaneous timeout.
        if (cmp_edge) begin
          vint_d  = 1'b1;
          state_d = ST_DONE;
        end else if (ch_zr) begin
          state_d = ST_DONE;
        end else if (deint_q == DEINT_TC) begin
          ovr_d   = 1'b1;
          vint_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          deint_d = deint_q + DW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state_q    <= ST_IDLE;
      cmp_sync_q <= '0;
      cmp_prev_q <= 1'b0;
      auto_q     <= '0;
      deint_q    <= '0;
      inicio_q   <= 1'b0;
      vint_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmp_sync_q <= cmp_sync_d;
      cmp_prev_q <= cmp_prev_d;
      auto_q     <= auto_d;
      deint_q    <= deint_d;
      inicio_q   <= inicio_d;
      vint_q     <= vint_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign inicio    = inicio_q;
  assign Vint_z    = vint_q;
  assign busy      = busy_q;
  assign overrange = ovr_q;

endmodule

// File: tb/tb_adc_trigger_sync.sv
// Directed bench for adc_trigger_sync: vector table plus multi-cycle corner sequences.
module tb_adc_trigger_sync;

  logic clk = 1'b0;
  logic rst_s, start_btn, auto_mode, vint_cmp, ch_vm, ch_vr, ch_zr;
  logic inicio, Vint_z, busy, overrange;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       btn;
    logic       cmp;
    logic       vm;
    logic       vr;
    logic       zr;
    logic [3:0] exp;  // {inicio, Vint_z, busy, overrange}
  } vec_t;

  vec_t tbl [0:27];

  adc_trigger_sync #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (20),
    .DEINT_TIMEOUT  (10)
  ) dut (
    .clk      (clk),
    .rst_s    (rst_s),
    .start_btn(start_btn),
    .auto_mode(auto_mode),
    .vint_cmp (vint_cmp),
    .ch_vm    (ch_vm),
    .ch_vr    (ch_vr),
    .ch_zr    (ch_zr),
    .inicio   (inicio),
    .Vint_z   (Vint_z),
    .busy     (busy),
    .overrange(overrange)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_row(input int i, input logic b, input logic c, input logic m,
                         input logic r, input logic z, input logic [3:0] e);
    tbl[i].btn = b; tbl[i].cmp = c; tbl[i].vm = m; tbl[i].vr = r; tbl[i].zr = z;
    tbl[i].exp = e;
  endtask

  // Button press from IDLE; inicio must land exactly 7 edges after the rise.
  task automatic press_start(input string nm);
    start_btn = 1'b1;
    repeat (6) tick();
    chk({nm, "_inicio_early"}, inicio, 0);
    tick();
    chk({nm, "_inicio"}, inicio, 1);
    chk({nm, "_ovr_cleared"}, overrange, 0);
    start_btn = 1'b0;
  endtask

  task automatic to_deint();
    ch_vm = 1'b1; tick(); ch_vm = 1'b0;
    ch_vr = 1'b1; tick(); ch_vr = 1'b0;
  endtask

  task automatic finish_conv();
    ch_vm = 1'b1; tick(); ch_vm = 1'b0;
    ch_vr = 1'b1; tick(); ch_vr = 1'b0;
    ch_zr = 1'b1; tick(); ch_zr = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int extra;
    logic seen;

    rst_s = 1'b1; start_btn = 1'b0; auto_mode = 1'b0; vint_cmp = 1'b0;
    ch_vm = 1'b0; ch_vr = 1'b0; ch_zr = 1'b0;

    // Bounce, trigger, masked comparator toggles, then a normal conversion.
    set_row( 0, 1, 0, 0, 0, 0, 4'b0000);
    set_row( 1, 0, 0, 0, 0, 0, 4'b0000);
    set_row( 2, 1, 0, 0, 0, 0, 4'b0000);
    set_row( 3, 0, 0, 0, 0, 0, 4'b0000);
    for (int i = 4; i <= 9; i++) set_row(i, 1, 0, 0, 0, 0, 4'b0000);
    set_row(10, 1, 0, 0, 0, 0, 4'b1010);
    set_row(11, 0, 1, 0, 0, 0, 4'b0010);
    set_row(12, 0, 0, 0, 0, 0, 4'b0010);
    set_row(13, 0, 1, 0, 0, 0, 4'b0010);
    set_row(14, 0, 0, 1, 0, 0, 4'b0010);
    set_row(15, 0, 1, 0, 0, 0, 4'b0010);
    set_row(16, 0, 0, 0, 0, 0, 4'b0010);
    set_row(17, 0, 1, 0, 0, 0, 4'b0010);
    for (int i = 18; i <= 21; i++) set_row(i, 0, 0, 0, 0, 0, 4'b0010);
    set_row(22, 0, 0, 0, 1, 0, 4'b0010);
    set_row(23, 0, 1, 0, 0, 0, 4'b0010);
    set_row(24, 0, 1, 0, 0, 0, 4'b0010);
    set_row(25, 0, 1, 0, 0, 0, 4'b0110);
    set_row(26, 0, 1, 0, 0, 0, 4'b0000);
    set_row(27, 0, 0, 0, 0, 0, 4'b0000);

    repeat (3) tick();
    chk("reset_outputs", {inicio, Vint_z, busy, overrange}, 0);
    rst_s = 1'b0;
    tick();
    chk("post_reset_outputs", {inicio, Vint_z, busy, overrange}, 0);

    for (int i = 0; i <= 27; i++) begin
      start_btn = tbl[i].btn; vint_cmp = tbl[i].cmp;
      ch_vm = tbl[i].vm; ch_vr = tbl[i].vr; ch_zr = tbl[i].zr;
      tick();
      chk($sformatf("vec%0d", i), {inicio, Vint_z, busy, overrange}, tbl[i].exp);
    end
    ch_vm = 1'b0; ch_vr = 1'b0; ch_zr = 1'b0; vint_cmp = 1'b0;
    repeat (4) tick();

    // Deintegration timeout with the comparator stuck low.
    press_start("to_start");
    to_deint();
    seen = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (overrange || Vint_z) seen = 1'b1;
    end
    chk("to_early_flag", seen, 0);
    tick();
    chk("to_overrange", overrange, 1);
    chk("to_forced_vint", Vint_z, 1);
    chk("to_busy_done", busy, 1);
    tick();
    chk("to_vint_single", Vint_z, 0);
    chk("to_idle", busy, 0);
    chk("to_sticky", overrange, 1);
    repeat (4) tick();

    // Next start clears overrange; an edge coinciding with timeout is a normal edge.
    press_start("ed_start");
    to_deint();
    repeat (7) tick();
    vint_cmp = 1'b1;
    tick();
    tick();
    chk("ed_pre_vint", Vint_z, 0);
    tick();
    chk("ed_vint", Vint_z, 1);
    chk("ed_no_overrange", overrange, 0);
    vint_cmp = 1'b0;
    repeat (5) tick();
    chk("ed_idle", busy, 0);

    // ch_zr ends deintegration; busy drops two edges later.
    press_start("zr_start");
    to_deint();
    ch_zr = 1'b1;
    tick();
    chk("zr_busy_done", busy, 1);
    chk("zr_no_vint", Vint_z, 0);
    ch_zr = 1'b0;
    tick();
    chk("zr_busy_low", busy, 0);
    repeat (8) tick();

    // Auto triggering, with a button press dropped while busy.
    auto_mode = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!inicio && n < 40);
    chk("auto_period1", n, 20);
    start_btn = 1'b1;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (inicio) extra++;
    end
    chk("auto_btn_dropped", extra, 0);
    start_btn = 1'b0;
    finish_conv();
    chk("auto_conv_idle", busy, 0);
    n = 0;
    do begin tick(); n++; end while (!inicio && n < 40);
    chk("auto_period2", n, 20);
    auto_mode = 1'b0;
    finish_conv();
    repeat (8) tick();

    // Reset mid-DEINT clears outputs without a clock edge.
    press_start("rst_start");
    to_deint();
    repeat (3) tick();
    chk("rst_busy_before", busy, 1);
    #2 rst_s = 1'b1;
    #1;
    chk("rst_async_outputs", {inicio, Vint_z, busy, overrange}, 0);
    tick();
    rst_s = 1'b0;
    tick();
    chk("rst_idle", {inicio, Vint_z, busy, overrange}, 0);
    press_start("rst_restart");
    finish_conv();
    chk("rst_restart_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
